counter_updn: RTL and testbench

COUNTER_UPDN -- requirements
Module: counter_updn

---
 rtl/counter_updn.sv | 67 ++++++
 tb/tb_counter_updn.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/counter_updn.sv
// Up/down counter with programmable terminal count, wrap or saturate at the
// boundaries, synchronous clear/load, combinational terminal-count and sticky boundary flag.
module counter_updn #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = (1 << WIDTH) - 1,
  parameter bit          SAT     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  if (MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_max
    $error("counter_updn: MAX_VAL out of range 1 .. 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_cnt, w_cnt_d;
  logic             r_ovf, w_ovf_d;
  logic             w_at_max, w_at_zero, w_bound;

  assign w_at_max  = (r_cnt == MaxCnt);
  assign w_at_zero = (r_cnt == '0);
  assign w_bound   = up ? w_at_max : w_at_zero;

  always_comb begin
    w_cnt_d = r_cnt;
    w_ovf_d = r_ovf;
    if (clr) begin
      w_cnt_d = '0;
      w_ovf_d = 1'b0;
    end else if (ld) begin
      w_cnt_d = (din > MaxCnt) ? MaxCnt : din;
    end else if (en) begin
      if (w_bound) begin
        w_ovf_d = 1'b1;
        // Wrap lands on the opposite boundary; saturate keeps the current one.
        if (!SAT) w_cnt_d = up ? '0 : MaxCnt;
      end else begin
        w_cnt_d = up ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_ovf <= w_ovf_d;
    end
  end

  assign out = r_cnt;
  assign ovf = r_ovf;
  assign tc  = en & ~clr & ~ld & w_bound;

endmodule

// File: tb/tb_counter_updn.sv
// Bench for counter_updn: three configurations share one stimulus stream and are
// checked every cycle against an arithmetic reference model plus literal anchors.
module tb_counter_updn;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0, ld = 1'b0, en = 1'b0, up = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] out8;
  logic [3:0] outw, outs;
  logic       tc8, tcw, tcs, ovf8, ovfw, ovfs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_updn #(.WIDTH(8), .MAX_VAL(255), .SAT(1'b0)) u_dut8 (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din), .en(en), .up(up),
    .out(out8), .tc(tc8), .ovf(ovf8)
  );
  counter_updn #(.WIDTH(4), .MAX_VAL(9), .SAT(1'b0)) u_dutw (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din[3:0]), .en(en), .up(up),
    .out(outw), .tc(tcw), .ovf(ovfw)
  );
  counter_updn #(.WIDTH(4), .MAX_VAL(9), .SAT(1'b1)) u_duts (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din[3:0]), .en(en), .up(up),
    .out(outs), .tc(tcs), .ovf(ovfs)
  );

  // Reference model: index 0 = 8-bit wrap/255, 1 = 4-bit wrap/9, 2 = 4-bit saturate/9.
  int unsigned mmax[3] = '{255, 9, 9};
  bit          msat[3] = '{1'b0, 1'b0, 1'b1};
  int unsigned mcnt[3];
  bit          movf[3];

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      int unsigned d, m;
      bit          bnd;
      m = mmax[i];
      d = (i == 0) ? int'(din) : int'(din[3:0]);
      if (!rst) begin
        mcnt[i] = 0;
        movf[i] = 1'b0;
      end else if (clr) begin
        mcnt[i] = 0;
        movf[i] = 1'b0;
      end else if (ld) begin
        mcnt[i] = (d > m) ? m : d;
      end else if (en) begin
        bnd = up ? (mcnt[i] == m) : (mcnt[i] == 0);
        if (bnd) movf[i] = 1'b1;
        if (!(bnd && msat[i]))
          mcnt[i] = up ? (mcnt[i] + 1) % (m + 1) : (mcnt[i] + m) % (m + 1);
      end
    end
  end

  function automatic bit model_tc(int i);
    return en && !clr && !ld && (up ? (mcnt[i] == mmax[i]) : (mcnt[i] == 0));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("model out8", int'(out8), int'(mcnt[0]));
    check("model outw", int'(outw), int'(mcnt[1]));
    check("model outs", int'(outs), int'(mcnt[2]));
    check("model ovf8", int'(ovf8), int'(movf[0]));
    check("model ovfw", int'(ovfw), int'(movf[1]));
    check("model ovfs", int'(ovfs), int'(movf[2]));
    check("model tc8", int'(tc8), int'(model_tc(0)));
    check("model tcw", int'(tcw), int'(model_tc(1)));
    check("model tcs", int'(tcs), int'(model_tc(2)));
  end

  // Apply inputs just after a falling edge; return just after the next falling edge.
  task automatic cyc(input bit c, input bit l, input bit e, input bit u, input logic [7:0] d);
    clr = c; ld = l; en = e; up = u; din = d;
    @(negedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk); #1;
    en = 1'b1; up = 1'b1; ld = 1'b1; din = 8'h33;
    @(negedge clk); #1;
    check("reset out8", int'(out8), 0);
    check("reset ovf8", int'(ovf8), 0);
    check("reset outs", int'(outs), 0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Free-running up count across all three configurations.
    for (int k = 1; k <= 260; k++) begin
      cyc(0, 0, 1, 1, 0);
      check("up out8", int'(out8), k % 256);
      check("up tc8", int'(tc8), int'(k % 256 == 255));
      check("up ovf8", int'(ovf8), int'(k >= 256));
      check("up outw", int'(outw), k % 10);
      check("up ovfw", int'(ovfw), int'(k >= 10));
      check("up outs", int'(outs), (k > 9) ? 9 : k);
      check("up tcs", int'(tcs), int'(k >= 9));
    end

    // Down count from zero.
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 1, 0, 0);
      check("down outw", int'(outw), (10 - k % 10) % 10);
      check("down outs", int'(outs), 0);
      check("down ovfs", int'(ovfs), 1);
      check("down out8", int'(out8), 256 - k);
    end
    cyc(0, 1, 0, 0, 8'd12);
    check("ld clamp outw", int'(outw), 9);
    check("ld clamp outs", int'(outs), 9);
    check("ld out8", int'(out8), 12);

    // Saturating: hold at 9 going up, then count down to 0 and hold.
    cyc(1, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) cyc(0, 0, 1, 1, 0);
    check("sat hi outs", int'(outs), 9);
    check("sat hi tcs", int'(tcs), 1);
    check("sat hi ovfs", int'(ovfs), 1);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 1, 0, 0);
      check("sat dn outs", int'(outs), (k > 9) ? 0 : 9 - k);
    end

    // Priority clr > ld > en.
    cyc(0, 1, 0, 0, 8'd7);
    cyc(1, 1, 1, 1, 8'd5);
    check("prio clr out8", int'(out8), 0);
    check("prio clr ovf8", int'(ovf8), 0);
    check("prio clr tc8", int'(tc8), 0);
    cyc(0, 1, 1, 1, 8'd5);
    check("prio ld out8", int'(out8), 5);
    check("prio ld tc8", int'(tc8), 0);

    // Hold with direction toggling.
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, k[0], 8'hFF);
      check("hold out8", int'(out8), 5);
      check("hold ovf8", int'(ovf8), 0);
      check("hold tcs", int'(tcs), 0);
    end

    // Asynchronous reset between edges.
    cyc(0, 1, 0, 0, 8'hFF);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 8'h37);
    check("pre-rst out8", int'(out8), 'h37);
    check("pre-rst ovf8", int'(ovf8), 1);
    #2 rst = 1'b0;
    #1;
    check("async rst out8", int'(out8), 0);
    check("async rst ovf8", int'(ovf8), 0);
    @(negedge clk); #1;
    rst = 1'b1;
    cyc(0, 0, 1, 1, 0);
    check("post-rst out8", int'(out8), 1);

    // Randomized traffic, including occasional mid-cycle resets.
    for (int k = 0; k < 4000; k++) begin
      bit c, l, e, u;
      c = ($urandom_range(99) < 3);
      l = ($urandom_range(99) < 8);
      e = ($urandom_range(99) < 75);
      u = ($urandom_range(99) < 8) ? ~up : up;
      cyc(c, l, e, u, 8'($urandom));
      if ($urandom_range(199) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
